// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller: debounced buttons feed a 4-state
// FSM that drives the 0.1 s count tick, counter clear and lap display freeze.

module stopwatch_btn #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1, s2, db, db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            db_q  <= db;
            press <= db & ~db_q;
            // cnt holds how many consecutive cycles s2 has disagreed with db
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int TICK_DIV        = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       lap,
    input  logic       clear,
    output logic       count_en,
    output logic       count_clr,
    output logic       disp_hold,
    output logic       running,
    output logic [1:0] state
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;

    state_t        st, nxt;
    logic [2:0]    raw, press;
    logic          ev_clr, ev_start, ev_lap, do_clr, counting;
    logic [PW-1:0] pre;

    assign raw   = {clear, lap, start};
    assign state = st;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        stopwatch_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clock (clock),
            .reset (reset),
            .raw   (raw[i]),
            .press (press[i])
        );
    end

    // clear > start > lap; the losers of a coincidence are dropped outright
    assign ev_clr   = press[2];
    assign ev_start = press[0] & ~press[2];
    assign ev_lap   = press[1] & ~press[0] & ~press[2];
    assign counting = (st == RUN) || (st == LAP);

    always_comb begin
        nxt    = st;
        do_clr = 1'b0;
        case (st)
            IDLE: begin
                if (ev_clr)        do_clr = 1'b1;
                else if (ev_start) nxt = RUN;
            end
            RUN: begin
                if (ev_start)      nxt = PAUSE;
                else if (ev_lap)   nxt = LAP;
            end
            LAP: begin
                if (ev_start)      nxt = PAUSE;
                else if (ev_lap)   nxt = RUN;
            end
            PAUSE: begin
                if (ev_clr) begin
                    nxt    = IDLE;
                    do_clr = 1'b1;
                end else if (ev_start) begin
                    nxt = RUN;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            pre       <= '0;
            count_en  <= 1'b0;
            count_clr <= 1'b0;
            disp_hold <= 1'b0;
            running   <= 1'b0;
        end else begin
            st        <= nxt;
            count_clr <= do_clr;
            disp_hold <= (nxt == LAP);
            running   <= (nxt == RUN) || (nxt == LAP);
            // prescaler freezes in PAUSE so a resume keeps the fractional tick
            if (counting) begin
                if (pre == PW'(TICK_DIV - 1)) begin
                    pre      <= '0;
                    count_en <= 1'b1;
                end else begin
                    pre      <= pre + 1'b1;
                    count_en <= 1'b0;
                end
            end else begin
                count_en <= 1'b0;
                if (st == IDLE || do_clr) pre <= '0;
            end
        end
    end
endmodule
